// File: rtl/interp_row_if.sv
// interp_row_if
//   Sample-in / result-out stream bundle for the interpolation row sequencer.
//   Ports (slave view, i.e. the sequencer side):
//     s_valid, s_data (in)  / s_ready (out)   input sample stream
//     m_valid, m_data (out) / m_ready (in)    filtered result stream
//   master is the mirror view used by whatever feeds and drains the sequencer.
interface interp_row_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH+1:0] s_data;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH+2:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/interp_row_ctrl.sv
// interp_row_ctrl
//   Row sequencer for an 8-tap half-sample interpolation filter. Streams one
//   row of samples into an 8-deep sliding window with edge replication on
//   both ends, presents the window to an external combinational filter and
//   registers the filter result into a valid/ready output stream. Exactly
//   ROW_LEN results (positions i+0.5) are produced per row.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     start            begin a row (only honoured in IDLE)
//     busy / done      row in progress / 1-cycle pulse after last result taken
//     sif              sample input and result output streams
//     tap0..tap7       window to filter in0..in7 (tap0 oldest)
//     filt_out         filter result for the current window
//
//   state | meaning
//   IDLE  | waiting for start
//   FILL  | taking samples 0..4; sample 0 replicated across the whole window
//   RUN   | taking samples 5..ROW_LEN-1, one result per shifted window
//   FLUSH | four shifts of w7 (right-edge replication), no input taken
//   DRAIN | waiting for the last window and last result to be consumed
module interp_row_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  interp_row_if.slave                  sif,
  output logic signed [DATA_WIDTH+1:0] tap0,
  output logic signed [DATA_WIDTH+1:0] tap1,
  output logic signed [DATA_WIDTH+1:0] tap2,
  output logic signed [DATA_WIDTH+1:0] tap3,
  output logic signed [DATA_WIDTH+1:0] tap4,
  output logic signed [DATA_WIDTH+1:0] tap5,
  output logic signed [DATA_WIDTH+1:0] tap6,
  output logic signed [DATA_WIDTH+1:0] tap7,
  input  logic signed [DATA_WIDTH+2:0] filt_out
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int RW = DATA_WIDTH + 3;
  localparam int CW = $clog2(ROW_LEN);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 busy_nxt, done_nxt;
  logic signed [SW-1:0] win [8];
  logic                 win_vld;
  logic                 m_valid_q;
  logic signed [RW-1:0] m_data_q;

  logic                 take, adv_ok;
  logic                 s_ready_c;
  logic                 win_load, win_shift, win_set;
  logic signed [SW-1:0] shift_in;

  // The current window's result moves to the output register when the
  // register is empty or being drained this cycle; the window may only move
  // once its own result is gone (or it never held one).
  assign take   = win_vld && (!m_valid_q || sif.m_ready);
  assign adv_ok = !win_vld || take;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    s_ready_c = 1'b0;
    win_load  = 1'b0;
    win_shift = 1'b0;
    win_set   = 1'b0;
    shift_in  = sif.s_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        s_ready_c = adv_ok;
        if (sif.s_valid && adv_ok) begin
          if (cnt == '0) win_load  = 1'b1;
          else           win_shift = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(4)) begin
            win_set = 1'b1;
            // a 5-sample row has no RUN phase: sample 4 is also the last
            if (ROW_LEN == 5) begin
              state_nxt = FLUSH;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RUN;
            end
          end
        end
      end
      RUN: begin
        s_ready_c = adv_ok;
        if (sif.s_valid && adv_ok) begin
          win_shift = 1'b1;
          win_set   = 1'b1;
          cnt_nxt   = cnt + CW'(1);
          if (cnt == CW'(ROW_LEN - 1)) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
          end
        end
      end
      FLUSH: begin
        if (adv_ok) begin
          win_shift = 1'b1;
          win_set   = 1'b1;
          shift_in  = win[7];
          cnt_nxt   = cnt + CW'(1);
          if (cnt == CW'(3)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // finish on the edge that consumes the last result
        if (!win_vld && (!m_valid_q || sif.m_ready)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_vld   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      for (int i = 0; i < 8; i++) win[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;

      if (win_load) begin
        for (int i = 0; i < 8; i++) win[i] <= sif.s_data;
      end else if (win_shift) begin
        for (int i = 0; i < 7; i++) win[i] <= win[i+1];
        win[7] <= shift_in;
      end

      // a fresh window outranks the take of the previous one
      if (win_set)   win_vld <= 1'b1;
      else if (take) win_vld <= 1'b0;

      if (take) begin
        m_valid_q <= 1'b1;
        m_data_q  <= filt_out;
      end else if (sif.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign sif.s_ready = s_ready_c;
  assign sif.m_valid = m_valid_q;
  assign sif.m_data  = m_data_q;

  assign tap0 = win[0];
  assign tap1 = win[1];
  assign tap2 = win[2];
  assign tap3 = win[3];
  assign tap4 = win[4];
  assign tap5 = win[5];
  assign tap6 = win[6];
  assign tap7 = win[7];

endmodule

// File: tb/tb_interp_row_ctrl.sv
// tb_interp_row_ctrl
//   Drives rows through interp_row_ctrl with an attached reference half-sample
//   filter and checks the result stream against results computed directly
//   from the row with clamped (edge-replicated) indexing.
module tb_interp_row_ctrl;
  localparam int DW = 8;
  localparam int RL = 8;
  localparam int SW = DW + 2;
  localparam int RW = DW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, busy, done;
  logic signed [SW-1:0] tap0, tap1, tap2, tap3, tap4, tap5, tap6, tap7;
  logic signed [RW-1:0] filt_out;
  logic [8*SW-1:0] taps_now;

  interp_row_if #(.DATA_WIDTH(DW)) bus();

  interp_row_ctrl #(.DATA_WIDTH(DW), .ROW_LEN(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .sif(bus),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
    .tap4(tap4), .tap5(tap5), .tap6(tap6), .tap7(tap7),
    .filt_out(filt_out)
  );

  function automatic int filt8(int a0, int a1, int a2, int a3,
                               int a4, int a5, int a6, int a7);
    int s;
    s = -a0 + 4*a1 - 11*a2 + 40*a3 + 40*a4 - 11*a5 + 4*a6 - a7;
    return s >>> 6;
  endfunction

  assign filt_out = RW'(filt8(int'(tap0), int'(tap1), int'(tap2), int'(tap3),
                              int'(tap4), int'(tap5), int'(tap6), int'(tap7)));
  assign taps_now = {tap0, tap1, tap2, tap3, tap4, tap5, tap6, tap7};

  int row_s [RL];
  int got   [RL];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // mode: 0 m_ready held high, 1 toggling, 2 random
  task automatic run_row(input int mode, input bit gaps, input bit spam);
    int exp_r [RL];
    int v [8];
    int idx, oidx, cyc, cyc5, first_mv;
    bit done_seen, prev_stall, stall_now;
    logic [8*SW-1:0] held;
    for (int k = 0; k < RL; k++) begin
      for (int j = 0; j < 8; j++) begin
        int p;
        p = k - 3 + j;
        if (p < 0) p = 0;
        if (p > RL - 1) p = RL - 1;
        v[j] = row_s[p];
      end
      exp_r[k] = filt8(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]);
    end

    @(negedge clk);
    start = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    #1 chk("done_single_pulse", int'(done), 0);
    @(negedge clk);

    idx = 0; oidx = 0; cyc = 0; cyc5 = -1; first_mv = -1;
    done_seen = 1'b0; prev_stall = 1'b0; held = '0;
    while (!done_seen && cyc < 2000) begin
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (cyc % 2 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      bus.s_valid = (idx < RL) && (!gaps || $urandom_range(0, 3) != 0);
      bus.s_data  = bus.s_valid ? SW'(row_s[idx]) : SW'($urandom);
      start = spam && ($urandom_range(0, 4) == 0);
      #1;
      if (prev_stall) chk("taps_held", int'(taps_now == held), 1);
      if (done) begin
        done_seen = 1'b1;
        chk("results_before_done", oidx, RL);
        chk("busy_at_done", int'(busy), 0);
      end else begin
        chk("busy_during_row", int'(busy), 1);
      end
      stall_now = !gaps && bus.m_valid && !bus.m_ready && idx >= 5;
      if (stall_now && idx < RL) chk("s_ready_stall", int'(bus.s_ready), 0);
      if (bus.s_valid && bus.s_ready) begin
        idx++;
        if (idx == 5) cyc5 = cyc;
      end
      if (bus.m_valid && first_mv < 0) first_mv = cyc;
      if (bus.m_valid && bus.m_ready) begin
        if (oidx < RL) begin
          chk($sformatf("result%0d", oidx), int'(bus.m_data), exp_r[oidx]);
          got[oidx] = int'(bus.m_data);
        end else begin
          chk("extra_result", oidx + 1, RL);
        end
        oidx++;
      end
      held = taps_now;
      prev_stall = stall_now;
      cyc++;
      if (!done_seen) @(negedge clk);
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    chk("row_completed", int'(done_seen), 1);
    chk("samples_taken", idx, RL);
    chk("result_count", oidx, RL);
    if (mode == 0 && !gaps) chk("first_result_latency", first_mv - cyc5, 2);
  endtask

  task automatic abort_row();
    int idx, cyc;
    @(negedge clk);
    start = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 200) begin
      bus.s_valid = 1'b1;
      bus.s_data  = SW'(row_s[idx]);
      #1;
      if (bus.s_valid && bus.s_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("abort_samples", idx, 6);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_m_valid", int'(bus.m_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_taps_zero", int'(taps_now == '0), 1);
    chk("rst_mid_s_ready", int'(bus.s_ready), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_s_ready", int'(bus.s_ready), 0);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_taps_zero", int'(taps_now == '0), 1);
    rst_n = 1'b1;

    for (int i = 0; i < RL; i++) row_s[i] = 100;
    run_row(0, 1'b0, 1'b0);

    for (int i = 0; i < RL; i++) row_s[i] = 10 * i;
    run_row(0, 1'b0, 1'b0);
    chk("ramp_result0", got[0], 4);
    chk("ramp_result3", got[3], 35);

    for (int i = 0; i < RL; i++) row_s[i] = -1;
    run_row(0, 1'b0, 1'b0);

    for (int i = 0; i < RL; i++) row_s[i] = 10 * i;
    run_row(1, 1'b0, 1'b0);
    chk("stall_ramp_result0", got[0], 4);
    chk("stall_ramp_result3", got[3], 35);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < RL; i++) row_s[i] = int'($urandom_range(0, 1023)) - 512;
      run_row(2, 1'b1, 1'b1);
    end

    for (int i = 0; i < RL; i++) row_s[i] = int'($urandom_range(0, 1023)) - 512;
    abort_row();
    for (int i = 0; i < RL; i++) row_s[i] = int'($urandom_range(0, 1023)) - 512;
    run_row(0, 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < RL; i++) row_s[i] = int'($urandom_range(0, 1023)) - 512;
      run_row(0, 1'b0, 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < RL; i++) row_s[i] = int'($urandom_range(0, 1023)) - 512;
      run_row(2, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
